instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'hE0000000, giving the PC value after reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum number of wait cycles per bus read before a fault.
REQ-003 SHALL have port clock  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous and active-low.
REQ-005 SHALL have port fetchStart  in  1  controller request to fetch the instruction at the PC.
REQ-006 SHALL have port jumpValid  in  1  load jumpTarget into the PC.
REQ-007 SHALL have port jumpTarget  in  32  new PC value.
REQ-008 SHALL have port faultClear  in  1  acknowledge a fault.
REQ-009 SHALL have port busWait  in  1  bus not ready; read data is invalid while high.
REQ-010 SHALL have port busReadData  in  32  bus read data (also wired directly to the instruction register).
REQ-011 SHALL have port busEnable  out  1  bus cycle active.
REQ-012 SHALL have port busWrite  out  1  tied to 0.
REQ-013 SHALL have port busSize  out  2  tied to 2'b10 (word).
REQ-014 SHALL have port busAddress  out  32  read address, equal to the PC.
REQ-015 SHALL have port irWriteEnable  out  1  load strobe for the instruction register.
REQ-016 SHALL have port fetchDone  out  1  one-cycle completion pulse.
REQ-017 SHALL have port fetchBusy  out  1  high whenever the state is not IDLE.
REQ-018 SHALL have port fetchedPc  out  32  address of the last completed fetch.
REQ-019 SHALL have port pc  out  32  current PC.
REQ-020 SHALL have port fault  out  1  high while in the ERROR state.
REQ-021 SHALL have port faultCause  out  2  01 = misaligned PC, 10 = timeout, 00 = no fault.

Function
REQ-022 SHALL implement the states IDLE, READ and ERROR.
REQ-023 SHALL, in IDLE with jumpValid=1, load pc <= jumpTarget.
REQ-024 SHALL, in IDLE with fetchStart=1, check the alignment of the effective address, which is jumpTarget if jumpValid=1, else pc.
REQ-025 SHALL, when that effective address has bits [1:0] != 0, go to ERROR with faultCause=01.
REQ-026 SHALL, when that effective address is aligned, go to READ with waitCount <= 0.
REQ-027 SHALL drive busEnable=1 and busAddress=pc in READ only; in other states busEnable=0 and busAddress=pc.
REQ-028 SHALL, in a READ cycle with busWait=0, assert irWriteEnable=1 and fetchDone=1 combinationally in that same cycle.
REQ-029 SHALL, in that same READ cycle with busWait=0, also update fetchedPc <= pc and pc <= pc+4 (modulo 2^32), then go to IDLE.
REQ-030 SHALL give a minimum fetch latency of 1 cycle in READ (fetchStart cycle -> strobe on the next cycle).
REQ-031 SHALL, in a READ cycle with busWait=1, increment waitCount.
REQ-032 SHALL, when waitCount == TIMEOUT_CYCLES and busWait=1, go to ERROR with faultCause=10 and leave pc unchanged.
REQ-033 SHALL ignore jumpValid and fetchStart while in READ.
REQ-034 SHALL hold fault=1 and busEnable=0 in ERROR.
REQ-035 SHALL accept jumpValid in ERROR and load pc <= jumpTarget.
REQ-036 SHALL, on faultClear=1 in ERROR, go to IDLE and set faultCause <= 00.
REQ-037 SHALL apply a jump and faultClear asserted in the same ERROR cycle together.
REQ-038 SHALL keep irWriteEnable and fetchDone at 0 in all cycles except the completing READ cycle.
REQ-039 SHALL use a waitCount wide enough for TIMEOUT_CYCLES.
REQ-040 SHALL compute pc+4 as a plain 32-bit sum, so 32'hFFFFFFFC wraps to 0.

Reset
REQ-041 SHALL, on a clock edge with reset=0, set state=IDLE, pc=RESET_VECTOR, fetchedPc=0, waitCount=0 and faultCause=00, with busEnable=0, irWriteEnable=0, fetchDone=0 and fault=0.
REQ-042 SHALL let reset override everything, including reset asserted in the middle of a READ; the aborted read produces no irWriteEnable.

Verification
REQ-043 SHALL cover: reset, then fetchStart with busWait=0 -> next cycle busAddress=E0000000, busEnable=1, irWriteEnable=1, then pc=E0000004 and fetchedPc=E0000000.
REQ-044 SHALL cover: busWait=1 for 3 cycles, then 0 -> busEnable high for 4 cycles, exactly one irWriteEnable pulse in the 4th cycle, pc advanced by 4.
REQ-045 SHALL cover: jumpValid=1 with jumpTarget=00001002 and fetchStart=1 -> fault=1, faultCause=01, busEnable never high; then faultClear -> IDLE with fault=0.
REQ-046 SHALL cover: TIMEOUT_CYCLES=4 with busWait held 1 -> ERROR entered after the 5th READ cycle with faultCause=10 and pc unchanged.
REQ-047 SHALL cover: pc=FFFFFFFC and a completed fetch -> pc=00000000 and fetchedPc=FFFFFFFC.
REQ-048 SHALL cover: reset=0 during READ with busWait=1 -> next cycle state IDLE, pc=E0000000, no irWriteEnable pulse.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-word instruction fetch sequencer with alignment and timeout faults
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'hE0000000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetchStart,
  input  logic        jumpValid,
  input  logic [31:0] jumpTarget,
  input  logic        faultClear,
  input  logic        busWait,
  input  logic [31:0] busReadData,
  output logic        busEnable,
  output logic        busWrite,
  output logic [1:0]  busSize,
  output logic [31:0] busAddress,
  output logic        irWriteEnable,
  output logic        fetchDone,
  output logic        fetchBusy,
  output logic [31:0] fetchedPc,
  output logic [31:0] pc,
  output logic        fault,
  output logic [1:0]  faultCause
);

  localparam int WCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WCW-1:0] TIMEOUT_W = WCW'(TIMEOUT_CYCLES);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    ERROR = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_next;
  logic [31:0]    r_pc;
  logic [31:0]    w_pc_next;
  logic [31:0]    r_fetched_pc;
  logic [31:0]    w_fetched_pc_next;
  logic [WCW-1:0] r_wait_count;
  logic [WCW-1:0] w_wait_count_next;
  logic [1:0]     r_fault_cause;
  logic [1:0]     w_fault_cause_next;
  logic [31:0]    w_eff_addr;
  logic           w_complete;
  logic [31:0]    w_unused_data;

  // Read data goes straight to the instruction register outside this block.
  assign w_unused_data = busReadData;

  assign w_eff_addr = jumpValid ? jumpTarget : r_pc;
  // A reset landing on the completing cycle must not strobe the IR.
  assign w_complete = (r_state == READ) && !busWait && reset;

  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_fetched_pc_next  = r_fetched_pc;
    w_wait_count_next  = r_wait_count;
    w_fault_cause_next = r_fault_cause;
    case (r_state)
      IDLE: begin
        if (jumpValid) w_pc_next = jumpTarget;
        if (fetchStart) begin
          if (w_eff_addr[1:0] != 2'b00) begin
            w_state_next       = ERROR;
            w_fault_cause_next = CAUSE_MISALIGN;
          end else begin
            w_state_next      = READ;
            w_wait_count_next = '0;
          end
        end
      end
      READ: begin
        if (!busWait) begin
          w_fetched_pc_next = r_pc;
          w_pc_next         = r_pc + 32'd4;
          w_state_next      = IDLE;
        end else if (r_wait_count == TIMEOUT_W) begin
          w_state_next       = ERROR;
          w_fault_cause_next = CAUSE_TIMEOUT;
        end else begin
          w_wait_count_next = r_wait_count + 1'b1;
        end
      end
      ERROR: begin
        if (jumpValid) w_pc_next = jumpTarget;
        if (faultClear) begin
          w_state_next       = IDLE;
          w_fault_cause_next = CAUSE_NONE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_pc          <= RESET_VECTOR;
      r_fetched_pc  <= '0;
      r_wait_count  <= '0;
      r_fault_cause <= CAUSE_NONE;
    end else begin
      r_state       <= w_state_next;
      r_pc          <= w_pc_next;
      r_fetched_pc  <= w_fetched_pc_next;
      r_wait_count  <= w_wait_count_next;
      r_fault_cause <= w_fault_cause_next;
    end
  end

  assign busEnable     = (r_state == READ);
  assign busWrite      = 1'b0;
  assign busSize       = 2'b10;
  assign busAddress    = r_pc;
  assign irWriteEnable = w_complete;
  assign fetchDone     = w_complete;
  assign fetchBusy     = (r_state != IDLE);
  assign fetchedPc     = r_fetched_pc;
  assign pc            = r_pc;
  assign fault         = (r_state == ERROR);
  assign faultCause    = r_fault_cause;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed vector bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        fetchStart;
  logic        jumpValid;
  logic [31:0] jumpTarget;
  logic        faultClear;
  logic        busWait;
  logic [31:0] busReadData;
  logic        busEnable;
  logic        busWrite;
  logic [1:0]  busSize;
  logic [31:0] busAddress;
  logic        irWriteEnable;
  logic        fetchDone;
  logic        fetchBusy;
  logic [31:0] fetchedPc;
  logic [31:0] pc;
  logic        fault;
  logic [1:0]  faultCause;

  int n_checks = 0;
  int n_errors = 0;

  instruction_fetch_unit #(
    .RESET_VECTOR  (32'hE0000000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fetchStart   (fetchStart),
    .jumpValid    (jumpValid),
    .jumpTarget   (jumpTarget),
    .faultClear   (faultClear),
    .busWait      (busWait),
    .busReadData  (busReadData),
    .busEnable    (busEnable),
    .busWrite     (busWrite),
    .busSize      (busSize),
    .busAddress   (busAddress),
    .irWriteEnable(irWriteEnable),
    .fetchDone    (fetchDone),
    .fetchBusy    (fetchBusy),
    .fetchedPc    (fetchedPc),
    .pc           (pc),
    .fault        (fault),
    .faultCause   (faultCause)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        fs;
    logic        jv;
    logic [31:0] jt;
    logic        fc;
    logic        bw;
    logic        e_en;
    logic        e_ir;
    logic        e_busy;
    logic        e_fault;
    logic [31:0] e_pc;
    logic [31:0] e_fpc;
    logic [1:0]  e_cause;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic fs, input logic jv, input logic [31:0] jt, input logic fc,
                     input logic bw, input logic e_en, input logic e_ir, input logic e_busy,
                     input logic e_fault, input logic [31:0] e_pc, input logic [31:0] e_fpc,
                     input logic [1:0] e_cause);
    vec_t v;
    v.fs = fs; v.jv = jv; v.jt = jt; v.fc = fc; v.bw = bw;
    v.e_en = e_en; v.e_ir = e_ir; v.e_busy = e_busy; v.e_fault = e_fault;
    v.e_pc = e_pc; v.e_fpc = e_fpc; v.e_cause = e_cause;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    fetchStart = 1'b0; jumpValid = 1'b0; jumpTarget = 32'h0;
    faultClear = 1'b0; busWait = 1'b0;
  endtask

  logic [31:0] prev_pc;

  initial begin
    busReadData = 32'hDEADBEEF;
    reset = 1'b0;
    idle_inputs();

    //   fs jv jt            fc bw  en ir busy flt pc_after      fpc_after     cause
    add(0, 0, 32'h0,         0, 0,  0, 0, 0, 0, 32'hE0000000, 32'h00000000, 2'b00);
    add(1, 0, 32'h0,         0, 0,  0, 0, 0, 0, 32'hE0000000, 32'h00000000, 2'b00);
    add(0, 0, 32'h0,         0, 0,  1, 1, 1, 0, 32'hE0000004, 32'hE0000000, 2'b00);
    add(1, 0, 32'h0,         0, 0,  0, 0, 0, 0, 32'hE0000004, 32'hE0000000, 2'b00);
    add(0, 0, 32'h0,         0, 1,  1, 0, 1, 0, 32'hE0000004, 32'hE0000000, 2'b00);
    add(1, 1, 32'h00000200,  0, 1,  1, 0, 1, 0, 32'hE0000004, 32'hE0000000, 2'b00);
    add(0, 0, 32'h0,         0, 1,  1, 0, 1, 0, 32'hE0000004, 32'hE0000000, 2'b00);
    add(0, 0, 32'h0,         0, 0,  1, 1, 1, 0, 32'hE0000008, 32'hE0000004, 2'b00);
    add(1, 1, 32'h00001002,  0, 0,  0, 0, 0, 0, 32'h00001002, 32'hE0000004, 2'b01);
    add(0, 0, 32'h0,         0, 0,  0, 0, 1, 1, 32'h00001002, 32'hE0000004, 2'b01);
    add(0, 0, 32'h0,         1, 0,  0, 0, 1, 1, 32'h00001002, 32'hE0000004, 2'b00);
    add(0, 0, 32'h0,         0, 0,  0, 0, 0, 0, 32'h00001002, 32'hE0000004, 2'b00);
    add(1, 1, 32'hFFFFFFFC,  0, 0,  0, 0, 0, 0, 32'hFFFFFFFC, 32'hE0000004, 2'b00);
    add(0, 1, 32'h12345678,  0, 0,  1, 1, 1, 0, 32'h00000000, 32'hFFFFFFFC, 2'b00);
    add(1, 0, 32'h0,         0, 1,  0, 0, 0, 0, 32'h00000000, 32'hFFFFFFFC, 2'b00);
    add(0, 0, 32'h0,         0, 1,  1, 0, 1, 0, 32'h00000000, 32'hFFFFFFFC, 2'b00);
    add(1, 1, 32'h00000100,  0, 1,  1, 0, 1, 0, 32'h00000000, 32'hFFFFFFFC, 2'b00);
    add(0, 0, 32'h0,         0, 1,  1, 0, 1, 0, 32'h00000000, 32'hFFFFFFFC, 2'b00);
    add(0, 0, 32'h0,         0, 1,  1, 0, 1, 0, 32'h00000000, 32'hFFFFFFFC, 2'b00);
    add(0, 0, 32'h0,         0, 1,  1, 0, 1, 0, 32'h00000000, 32'hFFFFFFFC, 2'b10);
    add(0, 0, 32'h0,         0, 1,  0, 0, 1, 1, 32'h00000000, 32'hFFFFFFFC, 2'b10);
    add(0, 1, 32'h00000040,  1, 0,  0, 0, 1, 1, 32'h00000040, 32'hFFFFFFFC, 2'b00);
    add(0, 0, 32'h0,         0, 0,  0, 0, 0, 0, 32'h00000040, 32'hFFFFFFFC, 2'b00);

    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", pc, 32'hE0000000);
    check("rst_fpc", fetchedPc, 32'h0);
    check("rst_cause", {30'h0, faultCause}, 32'h0);
    check("rst_en", {31'h0, busEnable}, 32'h0);
    check("rst_ir", {31'h0, irWriteEnable}, 32'h0);
    check("rst_fault", {31'h0, fault}, 32'h0);
    check("rst_busy", {31'h0, fetchBusy}, 32'h0);
    check("bus_write", {31'h0, busWrite}, 32'h0);
    check("bus_size", {30'h0, busSize}, 32'h2);
    @(negedge clock);
    reset = 1'b1;

    prev_pc = 32'hE0000000;
    foreach (vecs[i]) begin
      @(negedge clock);
      fetchStart = vecs[i].fs; jumpValid = vecs[i].jv; jumpTarget = vecs[i].jt;
      faultClear = vecs[i].fc; busWait   = vecs[i].bw;
      #1;
      check($sformatf("v%0d_en", i), {31'h0, busEnable}, {31'h0, vecs[i].e_en});
      check($sformatf("v%0d_ir", i), {31'h0, irWriteEnable}, {31'h0, vecs[i].e_ir});
      check($sformatf("v%0d_done", i), {31'h0, fetchDone}, {31'h0, vecs[i].e_ir});
      check($sformatf("v%0d_busy", i), {31'h0, fetchBusy}, {31'h0, vecs[i].e_busy});
      check($sformatf("v%0d_fault", i), {31'h0, fault}, {31'h0, vecs[i].e_fault});
      check($sformatf("v%0d_addr", i), busAddress, prev_pc);
      @(posedge clock);
      #1;
      check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
      check($sformatf("v%0d_fpc", i), fetchedPc, vecs[i].e_fpc);
      check($sformatf("v%0d_cause", i), {30'h0, faultCause}, {30'h0, vecs[i].e_cause});
      prev_pc = vecs[i].e_pc;
    end

    // Reset arriving mid-READ while the bus is stalled.
    @(negedge clock);
    idle_inputs();
    fetchStart = 1'b1;
    @(negedge clock);
    idle_inputs();
    busWait = 1'b1;
    reset   = 1'b0;
    #1;
    check("mr_en_before", {31'h0, busEnable}, 32'h1);
    check("mr_ir_before", {31'h0, irWriteEnable}, 32'h0);
    @(posedge clock);
    #1;
    check("mr_busy", {31'h0, fetchBusy}, 32'h0);
    check("mr_en", {31'h0, busEnable}, 32'h0);
    check("mr_ir", {31'h0, irWriteEnable}, 32'h0);
    check("mr_pc", pc, 32'hE0000000);
    check("mr_fpc", fetchedPc, 32'h0);
    check("mr_cause", {30'h0, faultCause}, 32'h0);
    @(negedge clock);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    #1;
    check("mr_after_busy", {31'h0, fetchBusy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
